// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronise, debounce and latch board switches for a processor handshake
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [8:0] SW,
    output logic [7:0] Data,
    output logic       Handshake,
    output logic       Rise,
    output logic       Fall
);

    // Last count value of a debounce window; reaching it with the level still held accepts the edge.
    localparam logic [15:0] C_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_RISING  = 2'd1,
        S_HIGH    = 2'd2,
        S_FALLING = 2'd3
    } state_t;

    logic [8:0]  r_s1;
    logic [8:0]  r_s2;
    state_t      r_state;
    logic [15:0] r_count;
    logic [7:0]  r_data;
    logic        r_handshake;
    logic        r_rise;
    logic        r_fall;
    logic        w_sw8;

    assign w_sw8     = r_s2[8];
    assign Data      = r_data;
    assign Handshake = r_handshake;
    assign Rise      = r_rise;
    assign Fall      = r_fall;

    // Two-flop synchroniser on all nine switch bits, nothing in between the stages.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_s1 <= 9'd0;
            r_s2 <= 9'd0;
        end else begin
            r_s1 <= SW;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM; the counter only advances below C_LAST so it can never wrap.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_LOW;
            r_count     <= 16'd0;
            r_data      <= 8'd0;
            r_handshake <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_sw8) begin
                        r_state <= S_RISING;
                        r_count <= 16'd1;
                    end else begin
                        r_count <= 16'd0;
                    end
                end
                S_RISING: begin
                    if (!w_sw8) begin
                        r_state <= S_LOW;
                        r_count <= 16'd0;
                    end else if (r_count == C_LAST) begin
                        r_state     <= S_HIGH;
                        r_count     <= 16'd0;
                        r_handshake <= 1'b1;
                        r_rise      <= 1'b1;
                        // Data is captured only here, so it stays frozen while Handshake is high.
                        r_data      <= r_s2[7:0];
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (!w_sw8) begin
                        r_state <= S_FALLING;
                        r_count <= 16'd1;
                    end else begin
                        r_count <= 16'd0;
                    end
                end
                S_FALLING: begin
                    if (w_sw8) begin
                        r_state <= S_HIGH;
                        r_count <= 16'd0;
                    end else if (r_count == C_LAST) begin
                        r_state     <= S_LOW;
                        r_count     <= 16'd0;
                        r_handshake <= 1'b0;
                        r_fall      <= 1'b1;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                default: begin
                    r_state     <= S_LOW;
                    r_count     <= 16'd0;
                    r_handshake <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - vector table, corner sequences and press scoreboard for switch_conditioner
module tb_switch_conditioner;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic [8:0] SW_a = 9'd0;
    logic [8:0] SW_b = 9'd0;
    logic [7:0] Data_a, Data_b;
    logic       Handshake_a, Handshake_b;
    logic       Rise_a, Rise_b, Fall_a, Fall_b;

    int n_vec = 0;
    int n_err = 0;
    int rises_a = 0, falls_a = 0;
    int rises_b = 0, falls_b = 0;
    logic [7:0] sb_q[$];

    always #5 Clock = ~Clock;

    switch_conditioner #(.DEBOUNCE_CYCLES(4)) u_dut_a (
        .Clock(Clock), .nReset(nReset), .SW(SW_a),
        .Data(Data_a), .Handshake(Handshake_a), .Rise(Rise_a), .Fall(Fall_a)
    );

    switch_conditioner u_dut_b (
        .Clock(Clock), .nReset(nReset), .SW(SW_b),
        .Data(Data_b), .Handshake(Handshake_b), .Rise(Rise_b), .Fall(Fall_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counters and the Rise/Fall exclusivity check for the short-debounce instance.
    always @(negedge Clock) begin
        if (nReset) begin
            if (Rise_a) rises_a++;
            if (Fall_a) falls_a++;
            if (Rise_a && Fall_a) check("rise_fall_same_cycle", 32'd1, 32'd0);
        end
    end

    // Scoreboard: every accepted press on the default instance must present the pressed data.
    always @(negedge Clock) begin
        if (nReset) begin
            if (Fall_b) falls_b++;
            if (Rise_b) begin
                rises_b++;
                if (sb_q.size() == 0) begin
                    check("rise_b_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rise_b_data", {24'd0, Data_b}, {24'd0, sb_q.pop_front()});
                end
            end
        end
    end

    typedef struct {
        logic [8:0] sw;
        int         cycles;
        logic       exp_hs;
        logic [7:0] exp_data;
        int         exp_rise;
        int         exp_fall;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int r0, f0;
        logic [7:0] d;

        vecs[0]  = '{9'h000, 5, 1'b0, 8'h00, 0, 0};
        vecs[1]  = '{9'h155, 2, 1'b0, 8'h00, 0, 0};  // 2-cycle glitch
        vecs[2]  = '{9'h000, 8, 1'b0, 8'h00, 0, 0};
        vecs[3]  = '{9'h0A5, 3, 1'b0, 8'h00, 0, 0};
        vecs[4]  = '{9'h1A5, 8, 1'b1, 8'hA5, 1, 0};
        vecs[5]  = '{9'h13C, 6, 1'b1, 8'hA5, 0, 0};  // data change while high
        vecs[6]  = '{9'h03C, 8, 1'b0, 8'hA5, 0, 1};
        vecs[7]  = '{9'h13C, 3, 1'b0, 8'hA5, 0, 0};  // one cycle short of acceptance
        vecs[8]  = '{9'h03C, 8, 1'b0, 8'hA5, 0, 0};
        vecs[9]  = '{9'h1C3, 8, 1'b1, 8'hC3, 1, 0};
        vecs[10] = '{9'h0C3, 3, 1'b1, 8'hC3, 0, 0};  // short low glitch in HIGH
        vecs[11] = '{9'h1C3, 6, 1'b1, 8'hC3, 0, 0};
        vecs[12] = '{9'h0C3, 8, 1'b0, 8'hC3, 0, 1};

        nReset = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_data", {24'd0, Data_a}, 32'd0);
        check("reset_hs", {31'd0, Handshake_a}, 32'd0);
        check("reset_rise_fall", {30'd0, Rise_a, Fall_a}, 32'd0);
        nReset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            r0 = rises_a;
            f0 = falls_a;
            SW_a = vecs[i].sw;
            repeat (vecs[i].cycles) @(negedge Clock);
            check($sformatf("vec%0d_hs", i), {31'd0, Handshake_a}, {31'd0, vecs[i].exp_hs});
            check($sformatf("vec%0d_data", i), {24'd0, Data_a}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_rise", i), rises_a - r0, vecs[i].exp_rise);
            check($sformatf("vec%0d_fall", i), falls_a - f0, vecs[i].exp_fall);
        end

        // Exact latency: the edge lands on the sixth rising clock after the switch changes.
        SW_a = 9'h15A;
        repeat (5) @(negedge Clock);
        check("lat_rise_early", {30'd0, Handshake_a, Rise_a}, 32'd0);
        @(negedge Clock);
        check("lat_rise_on", {30'd0, Handshake_a, Rise_a}, 32'd3);
        check("lat_rise_data", {24'd0, Data_a}, 32'h5A);
        @(negedge Clock);
        check("lat_rise_single", {30'd0, Handshake_a, Rise_a}, 32'd2);
        SW_a = 9'h05A;
        repeat (5) @(negedge Clock);
        check("lat_fall_early", {30'd0, Handshake_a, Fall_a}, 32'd2);
        @(negedge Clock);
        check("lat_fall_on", {30'd0, Handshake_a, Fall_a}, 32'd1);
        @(negedge Clock);
        check("lat_fall_single", {30'd0, Handshake_a, Fall_a}, 32'd0);

        // Toggling every cycle must never be accepted.
        r0 = rises_a;
        f0 = falls_a;
        for (int i = 0; i < 50; i++) begin
            SW_a = {i[0], 8'h77};
            @(negedge Clock);
        end
        SW_a = 9'h077;
        repeat (4) @(negedge Clock);
        check("toggle_rise", rises_a - r0, 0);
        check("toggle_fall", falls_a - f0, 0);
        check("toggle_hs", {31'd0, Handshake_a}, 32'd0);

        // Reset between clock edges in the middle of a rising debounce.
        SW_a = 9'h1FF;
        repeat (4) @(negedge Clock);
        @(posedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        check("async_rst_data", {24'd0, Data_a}, 32'd0);
        check("async_rst_flags", {29'd0, Handshake_a, Rise_a, Fall_a}, 32'd0);
        @(negedge Clock);
        #2;
        nReset = 1'b1;
        @(negedge Clock);
        r0 = rises_a;
        repeat (4) @(negedge Clock);
        check("post_rst_early", {30'd0, Handshake_a, Rise_a}, 32'd0);
        check("post_rst_no_rise", rises_a - r0, 0);
        @(negedge Clock);
        check("post_rst_rise", {30'd0, Handshake_a, Rise_a}, 32'd3);
        check("post_rst_data", {24'd0, Data_a}, 32'hFF);

        // Random presses on the default instance, 20 cycles high then 20 low.
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom_range(0, 255));
            sb_q.push_back(d);
            SW_b = {1'b1, d};
            repeat (20) @(negedge Clock);
            SW_b = {1'b0, 8'($urandom_range(0, 255))};
            repeat (20) @(negedge Clock);
        end
        check("rand_rise_count", rises_b, 1000);
        check("rand_fall_count", falls_b, 1000);
        check("rand_queue_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive synchronised cycles SW[8] must hold a new level before it is accepted; legal range 2..65535.
REQ-002 Clock  input  1  system clock; all state changes on rising edge.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 SW  input  9  raw board switches; SW[7:0] data, SW[8] handshake; asynchronous to Clock.
REQ-005 Data  output  8  conditioned data value presented to the processor.
REQ-006 Handshake  output  1  debounced, synchronised level of SW[8].
REQ-007 Rise  output  1  one-cycle pulse on accepted 0->1 transition of Handshake.
REQ-008 Fall  output  1  one-cycle pulse on accepted 1->0 transition of Handshake.

Function
REQ-009 The block SHALL pass all 9 SW bits through a 2-flop synchroniser (s1, s2); no logic between the flops.
REQ-010 The block SHALL implement a 4-state FSM: LOW, RISING, HIGH, FALLING.
REQ-011 LOW: s2[8]=1 -> RISING with counter=1; else stay, counter=0.
REQ-012 RISING: s2[8]=0 -> LOW, counter=0; s2[8]=1 and counter=DEBOUNCE_CYCLES-1 -> HIGH; else counter+1.
REQ-013 HIGH: s2[8]=0 -> FALLING with counter=1; else stay, counter=0.
REQ-014 FALLING: s2[8]=1 -> HIGH, counter=0; s2[8]=0 and counter=DEBOUNCE_CYCLES-1 -> LOW; else counter+1.
REQ-015 Handshake SHALL be 1 in HIGH and FALLING, 0 in LOW and RISING; registered, no glitches.
REQ-016 Rise SHALL be 1 for exactly the cycle following the RISING->HIGH edge; Fall likewise for FALLING->LOW.
REQ-017 Data SHALL load s2[7:0] on the RISING->HIGH edge and hold at all other times, so Data is stable while Handshake=1.
REQ-018 Latency: SW[8] settled before edge k -> Handshake/Rise assert after edge k+DEBOUNCE_CYCLES+1 (2 sync edges + DEBOUNCE_CYCLES-1 count edges).
REQ-019 Any SW[8] pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change on Handshake, Rise, Fall or Data.
REQ-020 SW[7:0] changes while in HIGH or FALLING SHALL NOT affect Data.
REQ-021 Counter SHALL be 16 bits and SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-022 Rise and Fall SHALL never be 1 in the same cycle.
REQ-023 With default DEBOUNCE_CYCLES, a switch held 20 cycles SHALL be accepted (17-cycle latency).

Reset
REQ-024 nReset=0 SHALL immediately, independent of Clock, force s1=s2=0, state=LOW, counter=0, Data=0, Handshake=0, Rise=0, Fall=0.
REQ-025 Reset mid-debounce or mid-pulse SHALL abort it; no Rise/Fall emitted on or after release for a transition begun before reset.
REQ-026 After nReset rises, an SW[8] held high SHALL be treated as a new 0->1 transition with full REQ-018 latency.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-027 SW=0x0A5 then SW[8]=1 held -> after 5 edges Handshake=1, Rise=1 for one cycle, Data=0xA5; Fall=0.
REQ-028 SW[8] high for 2 cycles then low -> Handshake, Rise, Fall, Data unchanged from 0.
REQ-029 In HIGH with Data=0xA5, SW[7:0]=0x3C then SW[8]=0 held -> Data stays 0xA5; Fall pulses once 5 edges later; Handshake=0.
REQ-030 SW[8] toggling every cycle for 50 cycles -> no Rise/Fall, Handshake=0.
REQ-031 nReset asserted 2 cycles into RISING, between clock edges -> all outputs 0 immediately; SW[8] held high after release -> Rise 5 edges after release.
REQ-032 Default DEBOUNCE_CYCLES=16, 1000 random (data, SW[8] 20-cycle high/low) sequences -> every Rise has Data equal to SW[7:0] at that press; Rise count = press count.
